// File: rtl/arb_rr_burst_ctrl_if.sv
// Bus between two requesters and the round-robin burst arbiter.
// The master side drives requests and data; the slave side returns grants and the selected data.
interface arb_rr_burst_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_0;
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  req_1;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  grant_0;
  logic                  grant_1;
  logic [DATA_WIDTH-1:0] arb_out;
  logic                  arb_valid;
  logic                  owner;

  modport master (
    output req_0, data_in0, req_1, data_in1,
    input  grant_0, grant_1, arb_out, arb_valid, owner
  );

  modport slave (
    input  req_0, data_in0, req_1, data_in1,
    output grant_0, grant_1, arb_out, arb_valid, owner
  );
endinterface

// File: rtl/arb_rr_burst_ctrl.sv
// Two-port round-robin arbiter with bounded bursts under contention.
// Grants come from the state register; arb_out/arb_valid register each transfer.
module arb_rr_burst_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input logic                clk,
  input logic                reset,
  arb_rr_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t                state;
  state_t                state_next;
  logic [1:0]            rst_pipe;
  logic                  rst_int;
  logic [7:0]            burst_cnt;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] arb_out_q;
  logic                  arb_valid_q;
  logic                  xfer0;
  logic                  xfer1;
  logic                  last_beat;
  logic                  entering;

  // Reset asserts immediately but releases two edges later, keeping the FSM in IDLE meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int   = rst_pipe[1];
  assign xfer0     = (state == GNT0) && bus.req_0;
  assign xfer1     = (state == GNT1) && bus.req_1;
  assign last_beat = (burst_cnt == LAST_BEAT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          state_next = owner_q ? GNT0 : GNT1;
        end else if (bus.req_0) begin
          state_next = GNT0;
        end else if (bus.req_1) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!bus.req_0) begin
          state_next = bus.req_1 ? GNT1 : IDLE;
        end else if (bus.req_1 && last_beat) begin
          state_next = GNT1;
        end
      end
      GNT1: begin
        if (!bus.req_1) begin
          state_next = bus.req_0 ? GNT0 : IDLE;
        end else if (bus.req_0 && last_beat) begin
          state_next = GNT0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh grant (from IDLE or a direct handover) restarts the burst count and moves ownership.
  assign entering = (state_next != state) && (state_next != IDLE);

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      burst_cnt   <= 8'd0;
      owner_q     <= 1'b1;
      arb_out_q   <= '0;
      arb_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      arb_valid_q <= xfer0 || xfer1;
      if (xfer0) begin
        arb_out_q <= bus.data_in0;
      end else if (xfer1) begin
        arb_out_q <= bus.data_in1;
      end
      if (entering) begin
        burst_cnt <= 8'd0;
        owner_q   <= (state_next == GNT1);
      end else if ((xfer0 || xfer1) && (burst_cnt != 8'hFF)) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  assign bus.grant_0   = (state == GNT0);
  assign bus.grant_1   = (state == GNT1);
  assign bus.arb_out   = arb_out_q;
  assign bus.arb_valid = arb_valid_q;
  assign bus.owner     = owner_q;

endmodule

// File: doc/arb_rr_burst_ctrl.md
ARB_RR_BURST_CTRL -- requirements
Module: arb_rr_burst_ctrl

Parameters
REQ-001 SHALL provide DATA_WIDTH, default 32, width of each requester data bus and arb_out.
REQ-002 SHALL provide MAX_BURST, default 8, legal range 2..255, maximum consecutive transfers granted to one requester while the other is requesting.

Interface
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req_0  input  1  requester 0 wants / holds the resource.
REQ-006 SHALL have data_in0  input  DATA_WIDTH  requester 0 data.
REQ-007 SHALL have req_1  input  1  requester 1 wants / holds the resource.
REQ-008 SHALL have data_in1  input  DATA_WIDTH  requester 1 data.
REQ-009 SHALL have grant_0  output  1  requester 0 owns the resource.
REQ-010 SHALL have grant_1  output  1  requester 1 owns the resource.
REQ-011 SHALL have arb_out  output  DATA_WIDTH  registered data of the last transfer.
REQ-012 SHALL have arb_valid  output  1  arb_out updated by a transfer on the previous edge.
REQ-013 SHALL have owner  output  1  last requester granted (0/1).

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1; grant_0 = (state==GNT0), grant_1 = (state==GNT1), both driven from registers; grant_0 and grant_1 never high together.
REQ-015 IDLE: req_0 only -> GNT0; req_1 only -> GNT1; both -> GNTx where x = !owner; neither -> stay IDLE.
REQ-016 Grant latency: request sampled at edge n -> grant high after edge n (one cycle); no grant issued combinationally.
REQ-017 Transfer cycle: grant_x=1 and req_x=1 at an edge -> arb_out <= data_inx, arb_valid <= 1 at that edge; any other edge -> arb_valid <= 0, arb_out holds its value.
REQ-018 burst_cnt (8 bits) SHALL clear on every entry into GNT0/GNT1 and increment on each transfer cycle, saturating at 255.
REQ-019 GNTx with req_x=0: -> GNTy if req_y=1, else IDLE; no transfer that edge.
REQ-020 GNTx with req_x=1 and this transfer is the MAX_BURST-th (burst_cnt==MAX_BURST-1) and req_y=1: transfer completes, then -> GNTy (forced handover, no IDLE gap).
REQ-021 GNTx with req_x=1 otherwise: stay GNTx; with req_y=0 bursts are unlimited.
REQ-022 owner SHALL update to x on every entry into GNTx (from IDLE or direct handover) and hold otherwise.
REQ-023 Handover GNT0<->GNT1 SHALL take effect in one edge; the losing grant falls on the same edge the winning grant rises.
REQ-024 Requester data SHALL be ignored whenever its grant is low.

Reset
REQ-025 reset high SHALL immediately (asynchronously) force state=IDLE, grant_0=0, grant_1=0, arb_out=0, arb_valid=0, burst_cnt=0, owner=1 (so port 0 wins the first contention).
REQ-026 Reset mid-burst SHALL abort the burst with no further transfer; after release, arbitration restarts from IDLE with owner=1.
REQ-027 Deassertion of reset SHALL be synchronized to clk internally so the FSM leaves IDLE no earlier than the second edge after release.

Verification
REQ-028 Single requester: req_0=1, data_in0=0xA5A5_0001 then +1 per cycle, 3 cycles -> grant_0 one cycle later, arb_out 0xA5A5_0001..0003 with arb_valid=1, then req_0=0 -> IDLE, grant_0=0, arb_valid=0.
REQ-029 Simultaneous first request after reset: req_0=req_1=1 -> grant_0 first, owner=0; after 8 transfers grant_1=1 same edge grant_0=0, owner=1.
REQ-030 Round-robin alternation: both held high for 40 cycles, MAX_BURST=8 -> grants alternate in blocks of exactly 8 transfers, no idle cycle, never both grants high.
REQ-031 Unlimited burst: req_0=1 for 300 cycles, req_1=0 -> grant_0 stays high throughout, burst_cnt saturates at 255, no handover.
REQ-032 Early release: GNT1 after 3 transfers drops req_1 while req_0=1 -> next edge grant_0=1, grant_1=0, no transfer on release edge (arb_valid=0).
REQ-033 Reset mid-burst: assert reset during 5th transfer of GNT0 -> grants, arb_out, arb_valid go 0 without a clock edge; after release with both requests, port 0 granted first.
